// File: rtl/player_control.sv
// player_control: player sprite movement, item holding state and chop/drop
// handshakes for the kitchen game. All outputs are registered.
// Optional feature: define PLAYER_DIAG_EN to move on both axes per frame.
module player_control #(
    parameter int X_START     = 64,
    parameter int Y_START     = 64,
    parameter int SPEED       = 2,
    parameter int X_MAX       = 1024,
    parameter int Y_MAX       = 768,
    parameter int WIDTH       = 32,
    parameter int HEIGHT      = 32,
    parameter int CHOP_FRAMES = 60
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic        frame_tick_in,
    input  logic        btn_up_in,
    input  logic        btn_down_in,
    input  logic        btn_left_in,
    input  logic        btn_right_in,
    input  logic        chop_in,
    input  logic        use_in,
    input  logic        pickup_in,
    input  logic [3:0]  pickup_item_in,
    input  logic        drop_in,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic [1:0]  player_direction,
    output logic [3:0]  player_state,
    output logic        chop_done_out,
    output logic        drop_valid_out,
    output logic [3:0]  drop_item_out
);

    typedef enum logic [3:0] {
        ST_NOTHING       = 4'd0,
        ST_CHOPPING      = 4'd1,
        ST_ONION_WHOLE   = 4'd2,
        ST_ONION_CHOPPED = 4'd3,
        ST_POT_EMPTY     = 4'd4,
        ST_POT_RAW       = 4'd5,
        ST_POT_COOKED    = 4'd6,
        ST_BOWL_EMPTY    = 4'd7,
        ST_BOWL_FULL     = 4'd8,
        ST_EXT_OFF       = 4'd9,
        ST_EXT_ON        = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_UP    = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_t;

    localparam int CNT_W = $clog2(CHOP_FRAMES + 1);
    localparam logic [CNT_W-1:0] CHOP_LAST = CNT_W'(CHOP_FRAMES);

    // Signed working widths: one bit beyond the coordinate so a step past
    // zero shows up as negative instead of wrapping.
    localparam logic signed [11:0] X_SPD = 12'(SPEED);
    localparam logic signed [11:0] X_LIM = 12'(X_MAX - WIDTH);
    localparam logic signed [10:0] Y_SPD = 11'(SPEED);
    localparam logic signed [10:0] Y_LIM = 11'(Y_MAX - HEIGHT);

    logic [10:0]      r_x;
    logic [9:0]       r_y;
    dir_t             r_dir;
    state_t           r_state;
    logic [CNT_W-1:0] r_chop_cnt;
    logic             r_chop_done;
    logic             r_drop_valid;
    logic [3:0]       r_drop_item;

    logic signed [11:0] w_x_sub;
    logic signed [11:0] w_x_add;
    logic signed [10:0] w_y_sub;
    logic signed [10:0] w_y_add;
    logic [10:0]        w_x_left;
    logic [10:0]        w_x_right;
    logic [9:0]         w_y_up;
    logic [9:0]         w_y_down;
    logic [10:0]        w_x_next;
    logic [9:0]         w_y_next;
    dir_t               w_dir_next;
    logic               w_item_ok;
    logic [CNT_W-1:0]   w_cnt_inc;

    assign w_x_sub = $signed({1'b0, r_x}) - X_SPD;
    assign w_x_add = $signed({1'b0, r_x}) + X_SPD;
    assign w_y_sub = $signed({1'b0, r_y}) - Y_SPD;
    assign w_y_add = $signed({1'b0, r_y}) + Y_SPD;

    assign w_x_left  = (w_x_sub < 12'sd0) ? '0 : w_x_sub[10:0];
    assign w_x_right = (w_x_add > X_LIM) ? X_LIM[10:0] : w_x_add[10:0];
    assign w_y_up    = (w_y_sub < 11'sd0) ? '0 : w_y_sub[9:0];
    assign w_y_down  = (w_y_add > Y_LIM) ? Y_LIM[9:0] : w_y_add[9:0];

    assign w_item_ok = (pickup_item_in >= 4'd2) && (pickup_item_in <= 4'd10);
    assign w_cnt_inc = r_chop_cnt + CNT_W'(1);

    // Candidate position/direction for this frame from the button levels
    always_comb begin
        w_x_next   = r_x;
        w_y_next   = r_y;
        w_dir_next = r_dir;
`ifdef PLAYER_DIAG_EN
        if (btn_up_in) begin
            w_y_next   = w_y_up;
            w_dir_next = DIR_UP;
        end else if (btn_down_in) begin
            w_y_next   = w_y_down;
            w_dir_next = DIR_DOWN;
        end
        // Horizontal component overrides the reported direction
        if (btn_left_in) begin
            w_x_next   = w_x_left;
            w_dir_next = DIR_LEFT;
        end else if (btn_right_in) begin
            w_x_next   = w_x_right;
            w_dir_next = DIR_RIGHT;
        end
`else
        if (btn_up_in) begin
            w_y_next   = w_y_up;
            w_dir_next = DIR_UP;
        end else if (btn_down_in) begin
            w_y_next   = w_y_down;
            w_dir_next = DIR_DOWN;
        end else if (btn_left_in) begin
            w_x_next   = w_x_left;
            w_dir_next = DIR_LEFT;
        end else if (btn_right_in) begin
            w_x_next   = w_x_right;
            w_dir_next = DIR_RIGHT;
        end
`endif
    end

    // Position and facing register; frozen while chopping
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            r_x   <= 11'(X_START);
            r_y   <= 10'(Y_START);
            r_dir <= DIR_DOWN;
        end else if (frame_tick_in && (r_state != ST_CHOPPING)) begin
            r_x   <= w_x_next;
            r_y   <= w_y_next;
            r_dir <= w_dir_next;
        end
    end

    // Held-item FSM with chop counter and registered chop/drop pulses
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            r_state      <= ST_NOTHING;
            r_chop_cnt   <= '0;
            r_chop_done  <= 1'b0;
            r_drop_valid <= 1'b0;
            r_drop_item  <= '0;
        end else begin
            r_chop_done  <= 1'b0;
            r_drop_valid <= 1'b0;
            case (r_state)
                ST_NOTHING: begin
                    if (pickup_in && w_item_ok) begin
                        r_state <= state_t'(pickup_item_in);
                    end else if (chop_in) begin
                        r_state    <= ST_CHOPPING;
                        r_chop_cnt <= '0;
                    end
                end
                ST_CHOPPING: begin
                    if (!chop_in) begin
                        r_state    <= ST_NOTHING;
                        r_chop_cnt <= '0;
                    end else if (frame_tick_in) begin
                        if (w_cnt_inc == CHOP_LAST) begin
                            r_state     <= ST_NOTHING;
                            r_chop_cnt  <= '0;
                            r_chop_done <= 1'b1;
                        end else begin
                            r_chop_cnt <= w_cnt_inc;
                        end
                    end
                end
                ST_ONION_WHOLE, ST_ONION_CHOPPED, ST_POT_EMPTY, ST_POT_RAW,
                ST_POT_COOKED, ST_BOWL_EMPTY, ST_BOWL_FULL, ST_EXT_OFF,
                ST_EXT_ON: begin
                    if (drop_in) begin
                        r_state      <= ST_NOTHING;
                        r_drop_valid <= 1'b1;
                        // A running extinguisher is handed over switched off
                        r_drop_item  <= (r_state == ST_EXT_ON) ? ST_EXT_OFF : r_state;
                    end else if ((r_state == ST_EXT_OFF) && use_in) begin
                        r_state <= ST_EXT_ON;
                    end else if ((r_state == ST_EXT_ON) && !use_in) begin
                        r_state <= ST_EXT_OFF;
                    end
                end
                default: r_state <= ST_NOTHING;
            endcase
        end
    end

    assign x_out            = r_x;
    assign y_out            = r_y;
    assign player_direction = r_dir;
    assign player_state     = r_state;
    assign chop_done_out    = r_chop_done;
    assign drop_valid_out   = r_drop_valid;
    assign drop_item_out    = r_drop_item;

endmodule

// File: doc/player_control.md
PLAYER_CONTROL -- requirements
Module: player_control

Interface
REQ-001 SHALL have parameters: X_START=64, initial x; Y_START=64, initial y; SPEED=2, pixels per frame; X_MAX=1024, right arena bound (exclusive); Y_MAX=768, bottom bound (exclusive); WIDTH=32, HEIGHT=32, sprite size; CHOP_FRAMES=60, frames per chop.
REQ-002 SHALL have ports, one clock, synchronous active-high reset:
 pixel_clk_in  in  1  sole clock
 rst_in  in  1  synchronous active-high reset
 frame_tick_in  in  1  one-cycle pulse once per frame
 btn_up_in, btn_down_in, btn_left_in, btn_right_in  in  1 each  level, debounced
 chop_in  in  1  level, chop held
 use_in  in  1  level, extinguisher trigger held
 pickup_in  in  1  one-cycle pickup request
 pickup_item_in  in  4  item offered by facing tile
 drop_in  in  1  one-cycle drop request
 x_out  out  11  sprite left edge
 y_out  out  10  sprite top edge
 player_direction  out  2  LEFT=0, RIGHT=1, UP=2, DOWN=3
 player_state  out  4  NOTHING=0, CHOPPING=1, ONION_WHOLE=2, ONION_CHOPPED=3, POT_EMPTY=4, POT_RAW=5, POT_COOKED=6, BOWL_EMPTY=7, BOWL_FULL=8, EXT_OFF=9, EXT_ON=10
 chop_done_out  out  1  one-cycle pulse, chop complete
 drop_valid_out  out  1  one-cycle pulse, item dropped
 drop_item_out  out  4  dropped item code, valid with drop_valid_out

Function
REQ-003 SHALL register all outputs; every effect of an input sampled at edge N SHALL be visible after edge N.
REQ-004 SHALL update position only in cycles with frame_tick_in=1 and player_state != CHOPPING.
REQ-005 SHALL, without diagonal mode, move on one axis per frame, priority up > down > left > right, by SPEED pixels.
REQ-006 SHALL clamp x to [0, X_MAX-WIDTH] and y to [0, Y_MAX-HEIGHT], computing in 12/11-bit signed to avoid wrap; a move into a bound SHALL land exactly on the bound.
REQ-007 SHALL set player_direction to the moved direction on every frame tick with a button pressed, including when clamped; no button: direction held.
REQ-008 SHALL in NOTHING accept pickup_in when pickup_item_in in 2..10: player_state <= pickup_item_in; codes 0, 1, 11..15 ignored.
REQ-009 SHALL ignore pickup_in in any state other than NOTHING.
REQ-010 SHALL in NOTHING with chop_in=1 and no pickup_in enter CHOPPING, chop counter cleared; pickup_in wins over chop_in.
REQ-011 SHALL in CHOPPING increment chop counter on each frame_tick_in while chop_in=1; on tick where counter reaches CHOP_FRAMES, pulse chop_done_out one cycle and return to NOTHING.
REQ-012 SHALL on chop_in=0 in CHOPPING return to NOTHING, clear counter, no chop_done_out.
REQ-013 SHALL in EXT_OFF with use_in=1 go to EXT_ON; in EXT_ON with use_in=0 go to EXT_OFF.
REQ-014 SHALL on drop_in in any state 2..10 go to NOTHING, pulse drop_valid_out, drop_item_out = prior state, with EXT_ON reported as 9.
REQ-015 SHALL ignore drop_in in NOTHING and CHOPPING; drop_in takes priority over use_in in the same cycle.
REQ-016 SHALL hold drop_item_out at last dropped value between pulses.

Reset
REQ-017 SHALL on rst_in=1 set x_out=X_START, y_out=Y_START, player_direction=DOWN(3), player_state=NOTHING, chop counter=0, chop_done_out=0, drop_valid_out=0, drop_item_out=0.
REQ-018 SHALL give rst_in priority over all inputs, including mid-chop and frame_tick_in in the same cycle.

Configuration
REQ-019 SHALL with PLAYER_DIAG_EN defined move both axes on one frame tick (vertical: up over down; horizontal: left over right), each axis clamped per REQ-006, direction = horizontal component.
REQ-020 SHALL without PLAYER_DIAG_EN follow REQ-005 single-axis priority exactly.

Verification
REQ-021 Reset, then btn_right held 3 frame ticks -> x_out=70, y_out=64, player_direction=1.
REQ-022 x_out=991, btn_right, one tick -> x_out=992 (clamp), direction=1; next tick x_out=992.
REQ-023 NOTHING, chop_in held 60 ticks -> player_state=1 throughout, chop_done_out high exactly one cycle after 60th tick, state=0; release at tick 30 -> state=0, no pulse.
REQ-024 pickup_in with item 2 -> state=2; drop_in -> state=0, drop_valid_out=1 one cycle, drop_item_out=2; pickup item 11 -> state stays 0.
REQ-025 state=9, use_in=1 -> 10; drop_in with use_in=1 -> state=0, drop_item_out=9.
REQ-026 PLAYER_DIAG_EN defined, btn_up+btn_left one tick from (64,64) -> (62,62), direction=0; undefined -> (64,62), direction=2.
